// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// A horizontal and a vertical counter advance on each pix_en & enable tick.
// Every output is a flop loaded from a decode of the next counter values,
// so no output can glitch from combinational decode.
module vga_timing_gen #(
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned H_VIS   = 640,
    parameter int unsigned V_FP    = 12,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 35,
    parameter int unsigned V_VIS   = 400,
    parameter int unsigned H_POL   = 0,
    parameter int unsigned V_POL   = 1,
    parameter int unsigned Y_SHIFT = 0,
    parameter int unsigned XW      = 10,
    parameter int unsigned YW      = 9,
    parameter int unsigned FW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_cnt
);

    localparam int unsigned H_TOT   = H_FP + H_SYNC + H_BP + H_VIS;
    localparam int unsigned V_TOT   = V_FP + V_SYNC + V_BP + V_VIS;
    localparam int unsigned H_START = H_FP + H_SYNC + H_BP;
    localparam int unsigned V_START = V_FP + V_SYNC + V_BP;
    localparam int unsigned HCW     = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int unsigned VCW     = (V_TOT > 1) ? $clog2(V_TOT) : 1;

    localparam logic [HCW-1:0] H_LAST_C      = HCW'(H_TOT - 1);
    localparam logic [VCW-1:0] V_LAST_C      = VCW'(V_TOT - 1);
    localparam logic [HCW-1:0] H_SYNC_BEG_C  = HCW'(H_FP);
    localparam logic [HCW-1:0] H_SYNC_END_C  = HCW'(H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_SYNC_BEG_C  = VCW'(V_FP);
    localparam logic [VCW-1:0] V_SYNC_END_C  = VCW'(V_FP + V_SYNC);
    localparam logic [HCW-1:0] H_START_C     = HCW'(H_START);
    localparam logic [VCW-1:0] V_START_C     = VCW'(V_START);
    localparam logic           H_ACT         = 1'(H_POL);
    localparam logic           V_ACT         = 1'(V_POL);

    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;
    logic [FW-1:0]  frame_cnt_q, frame_cnt_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           active_q, active_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;

    logic           tick;
    logic           h_last;
    logic           v_last;
    logic           h_vis;
    logic           v_vis;

    // Next-state: advance counters on a tick and decode outputs from the new counts.
    always_comb begin
        tick          = pix_en & enable;
        h_last        = (hcnt_q == H_LAST_C);
        v_last        = (vcnt_q == V_LAST_C);
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        frame_cnt_d   = frame_cnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        h_vis         = 1'b0;
        v_vis         = 1'b0;

        if (tick) begin
            hcnt_d = h_last ? '0 : hcnt_q + HCW'(1);
            if (h_last) begin
                vcnt_d = v_last ? '0 : vcnt_q + VCW'(1);
            end
            line_start_d  = h_last;
            frame_start_d = h_last & v_last;
            if (h_last & v_last) begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end

            h_vis    = (hcnt_d >= H_START_C);
            v_vis    = (vcnt_d >= V_START_C);
            hsync_d  = ((hcnt_d >= H_SYNC_BEG_C) && (hcnt_d < H_SYNC_END_C)) ? H_ACT : ~H_ACT;
            vsync_d  = ((vcnt_d >= V_SYNC_BEG_C) && (vcnt_d < V_SYNC_END_C)) ? V_ACT : ~V_ACT;
            active_d = h_vis & v_vis;
            x_d      = h_vis ? XW'(hcnt_d - H_START_C) : '0;
            y_d      = v_vis ? YW'((vcnt_d - V_START_C) >> Y_SHIFT) : '0;
        end
    end

    // State and output registers; reset parks the raster at (0,0) with syncs inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_cnt_q   <= '0;
            hsync_q       <= ~H_ACT;
            vsync_q       <= ~V_ACT;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_cnt_q   <= frame_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for the raster generator on a tiny
// 10x7 raster (dut_a) and a 10x8 double-scan raster (dut_b).
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_en;
    logic       enable;

    logic       a_hsync, a_vsync, a_active, a_ls, a_fs;
    logic [3:0] a_x, a_y;
    logic [7:0] a_fc;
    logic       b_hsync, b_vsync, b_active, b_ls, b_fs;
    logic [3:0] b_x, b_y;
    logic [7:0] b_fc;

    vga_timing_gen #(
        .H_FP(2), .H_SYNC(3), .H_BP(1), .H_VIS(4),
        .V_FP(1), .V_SYNC(2), .V_BP(1), .V_VIS(3),
        .H_POL(0), .V_POL(1), .Y_SHIFT(0), .XW(4), .YW(4), .FW(8)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .enable(enable),
        .hsync(a_hsync), .vsync(a_vsync), .active(a_active), .x(a_x), .y(a_y),
        .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .H_FP(2), .H_SYNC(3), .H_BP(1), .H_VIS(4),
        .V_FP(1), .V_SYNC(2), .V_BP(1), .V_VIS(4),
        .H_POL(0), .V_POL(1), .Y_SHIFT(1), .XW(4), .YW(4), .FW(8)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .enable(enable),
        .hsync(b_hsync), .vsync(b_vsync), .active(b_active), .x(b_x), .y(b_y),
        .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Hand-computed per-count expectations for the small raster.
    int exp_hs   [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    int exp_x    [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
    int exp_vs_a [7]  = '{0, 1, 1, 0, 0, 0, 0};
    int exp_y_a  [7]  = '{0, 0, 0, 0, 0, 1, 2};
    int exp_vs_b [8]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    int exp_y_b  [8]  = '{0, 0, 0, 0, 0, 0, 1, 1};

    // Reference raster position and strobes after the latest edge.
    int   m_h, m_va, m_vb, m_fa, m_fb;
    logic m_ls, m_fsa, m_fsb;
    logic last_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_h = 0; m_va = 0; m_vb = 0; m_fa = 0; m_fb = 0;
        m_ls = 1'b0; m_fsa = 1'b0; m_fsb = 1'b0;
    endtask

    task automatic check_all();
        chk("hsync_a",  32'(a_hsync),  32'(exp_hs[m_h]));
        chk("x_a",      32'(a_x),      32'(exp_x[m_h]));
        chk("vsync_a",  32'(a_vsync),  32'(exp_vs_a[m_va]));
        chk("y_a",      32'(a_y),      32'(exp_y_a[m_va]));
        chk("active_a", 32'(a_active), 32'((m_h >= 6 && m_va >= 4) ? 1 : 0));
        chk("ls_a",     32'(a_ls),     32'(m_ls));
        chk("fs_a",     32'(a_fs),     32'(m_fsa));
        chk("fc_a",     32'(a_fc),     32'(m_fa));
        chk("hsync_b",  32'(b_hsync),  32'(exp_hs[m_h]));
        chk("x_b",      32'(b_x),      32'(exp_x[m_h]));
        chk("vsync_b",  32'(b_vsync),  32'(exp_vs_b[m_vb]));
        chk("y_b",      32'(b_y),      32'(exp_y_b[m_vb]));
        chk("active_b", 32'(b_active), 32'((m_h >= 6 && m_vb >= 4) ? 1 : 0));
        chk("ls_b",     32'(b_ls),     32'(m_ls));
        chk("fs_b",     32'(b_fs),     32'(m_fsb));
        chk("fc_b",     32'(b_fc),     32'(m_fb));
    endtask

    // One clock: advance the reference on a tick, then sample 1ns after the edge.
    task automatic step();
        logic tk;
        tk = pix_en & enable;
        @(posedge clk);
        m_ls = 1'b0; m_fsa = 1'b0; m_fsb = 1'b0;
        if (tk) begin
            if (m_h == 9) begin
                m_h  = 0;
                m_ls = 1'b1;
                m_va = (m_va == 6) ? 0 : m_va + 1;
                m_vb = (m_vb == 7) ? 0 : m_vb + 1;
                if (m_va == 0) begin m_fsa = 1'b1; m_fa = (m_fa + 1) % 256; end
                if (m_vb == 0) begin m_fsb = 1'b1; m_fb = (m_fb + 1) % 256; end
            end else begin
                m_h = m_h + 1;
            end
        end
        last_tick = tk;
        #1;
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hsync"},  32'(a_hsync),  32'd1);
        chk({tag, "_vsync"},  32'(a_vsync),  32'd0);
        chk({tag, "_active"}, 32'(a_active), 32'd0);
        chk({tag, "_x"},      32'(a_x),      32'd0);
        chk({tag, "_y"},      32'(a_y),      32'd0);
        chk({tag, "_fc"},     32'(a_fc),     32'd0);
        chk({tag, "_ls"},     32'(a_ls),     32'd0);
        chk({tag, "_fs"},     32'(a_fs),     32'd0);
        chk({tag, "_b_y"},    32'(b_y),      32'd0);
        chk({tag, "_b_fc"},   32'(b_fc),     32'd0);
    endtask

    initial begin
        int   last_ls, last_fs, fs_seen, vs_cnt, act_cnt, first_ls;
        int   ybuf[$];
        logic p_hs, p_vs, p_act;
        logic [3:0] p_x;
        logic found;

        reset = 1'b1; pix_en = 1'b1; enable = 1'b1;
        model_reset();
        #12;
        check_reset_outputs("rst");
        reset = 1'b0;

        // Three free-running frames: per-pixel decode, strobe spacing, counts.
        last_ls = -1; last_fs = -1; fs_seen = 0; vs_cnt = 0; act_cnt = 0;
        for (int i = 1; i <= 240; i++) begin
            step();
            if (i <= 70) begin
                if (a_vsync === 1'b1)  vs_cnt++;
                if (a_active === 1'b1) act_cnt++;
            end
            if (m_h == 6 && b_active === 1'b1) ybuf.push_back(int'(b_y));
            if (i <= 210) begin
                if (a_ls === 1'b1) begin
                    if (last_ls >= 0) chk("ls_gap", 32'(i - last_ls), 32'd10);
                    last_ls = i;
                end
                if (a_fs === 1'b1) begin
                    chk("fs_with_ls", 32'(a_ls), 32'd1);
                    if (last_fs >= 0) chk("fs_gap", 32'(i - last_fs), 32'd70);
                    last_fs = i;
                    fs_seen++;
                    chk("fc_seq", 32'(a_fc), 32'(fs_seen));
                end
            end
        end
        chk("vsync_clks", 32'(vs_cnt), 32'd20);
        chk("active_clks", 32'(act_cnt), 32'd12);
        chk("frames_seen", 32'(fs_seen), 32'd3);
        chk("first_ls", 32'(last_ls - 200), 32'd10);
        chk("yseq_len", 32'(ybuf.size() >= 4 ? 1 : 0), 32'd1);
        if (ybuf.size() >= 4) begin
            chk("yseq0", 32'(ybuf[0]), 32'd0);
            chk("yseq1", 32'(ybuf[1]), 32'd0);
            chk("yseq2", 32'(ybuf[2]), 32'd1);
            chk("yseq3", 32'(ybuf[3]), 32'd1);
        end

        // Realign to a frame boundary of dut_a (240 ticks -> 30 ticks past it).
        for (int i = 0; i < 40; i++) step();

        // Half-rate pix_en: frames stretch to 140 clks, outputs hold on idle clks.
        last_fs = -1;
        for (int i = 1; i <= 300; i++) begin
            p_hs = a_hsync; p_vs = a_vsync; p_act = a_active; p_x = a_x;
            pix_en = i[0];
            step();
            if (!last_tick) begin
                chk("hold_hsync", 32'(a_hsync), 32'(p_hs));
                chk("hold_vsync", 32'(a_vsync), 32'(p_vs));
                chk("hold_active", 32'(a_active), 32'(p_act));
                chk("hold_x", 32'(a_x), 32'(p_x));
            end
            if (a_fs === 1'b1) begin
                if (last_fs >= 0) chk("fs_gap_half", 32'(i - last_fs), 32'd140);
                last_fs = i;
            end
        end
        pix_en = 1'b1;

        // Freeze with enable low while hsync is active at hcnt=3.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (m_h == 3) found = 1'b1;
        end
        chk("reach_h3", 32'(found), 32'd1);
        chk("h3_hsync", 32'(a_hsync), 32'd0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frz_hsync", 32'(a_hsync), 32'd0);
            chk("frz_x", 32'(a_x), 32'd0);
            chk("frz_ls", 32'(a_ls), 32'd0);
        end
        enable = 1'b1;
        step();
        chk("resume_h4_hsync", 32'(a_hsync), 32'd0);
        step();
        chk("resume_h5_hsync", 32'(a_hsync), 32'd1);

        // Asynchronous reset in the middle of a visible pixel (vcnt=5, hcnt=8).
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (m_va == 5 && m_h == 8) found = 1'b1;
        end
        chk("reach_v5h8", 32'(found), 32'd1);
        chk("pre_rst_active", 32'(a_active), 32'd1);
        chk("pre_rst_x", 32'(a_x), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        #1;
        reset = 1'b0;
        model_reset();
        first_ls = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (a_ls === 1'b1 && first_ls < 0) first_ls = i;
        end
        chk("ls_after_rst", 32'(first_ls), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
